// File: rtl/bmr_tdee_qsys_pio_led_pkg.sv
// Shared definitions for the BMR/TDEE output PIO: register word addresses and
// pulse-timer state encodings, common with the switch input PIO.
package bmr_tdee_qsys_pio_led_pkg;

  localparam logic [1:0] PIO_ADDR_DATA     = 2'd0;
  localparam logic [1:0] PIO_ADDR_PULSE    = 2'd1;
  localparam logic [1:0] PIO_ADDR_OUTSET   = 2'd2;
  localparam logic [1:0] PIO_ADDR_OUTCLEAR = 2'd3;

  localparam logic [0:0] PULSE_IDLE   = 1'b0;
  localparam logic [0:0] PULSE_ACTIVE = 1'b1;

endpackage

// File: rtl/bmr_tdee_qsys_pio_led_pulse_timer.sv
// Retriggerable one-shot: bits loaded into pulse_mask stay high for exactly
// PULSE_CYCLES clocks after the most recent non-zero load.
module bmr_tdee_pulse_timer
  import bmr_tdee_qsys_pio_led_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_mask,
  output logic [WIDTH-1:0] pulse_mask
);

  localparam int CNT_W = $clog2(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             load_nz_s;
  logic             term_s;

  assign load_nz_s = load && (load_mask != {WIDTH{1'b0}});
  assign term_s    = (cnt_q == CNT_LAST);

  // Next-state logic; on the terminal cycle a retrigger drops the expiring bits
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    case (state_q)
      PULSE_IDLE: begin
        if (load_nz_s) begin
          mask_d  = load_mask;
          cnt_d   = {CNT_W{1'b0}};
          state_d = PULSE_ACTIVE;
        end else begin
          mask_d  = mask_q;
          cnt_d   = cnt_q;
          state_d = PULSE_IDLE;
        end
      end
      PULSE_ACTIVE: begin
        if (load_nz_s) begin
          if (term_s) begin
            mask_d = load_mask;
          end else begin
            mask_d = mask_q | load_mask;
          end
          cnt_d   = {CNT_W{1'b0}};
          state_d = PULSE_ACTIVE;
        end else if (term_s) begin
          mask_d  = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = PULSE_IDLE;
        end else begin
          mask_d  = mask_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = PULSE_ACTIVE;
        end
      end
      default: begin
        mask_d  = {WIDTH{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        state_d = PULSE_IDLE;
      end
    endcase
  end

  // State, counter and mask registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PULSE_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      mask_q  <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  assign pulse_mask = mask_q;

endmodule

// File: rtl/bmr_tdee_qsys_pio_led.sv
// Avalon-MM output PIO: data register with atomic set/clear, plus a one-shot
// pulse register; out_port drives the board LEDs.
module bmr_tdee_qsys_pio_led
  import bmr_tdee_qsys_pio_led_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               PULSE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] wd_s;
  logic [WIDTH-1:0] pulse_mask_s;
  logic             write_s;
  logic             pulse_load_s;
  logic             unused_wd_s;

  assign write_s      = chipselect && !write_n;
  assign wd_s         = writedata[WIDTH-1:0];
  assign unused_wd_s  = ^writedata;
  assign pulse_load_s = write_s && (address == PIO_ADDR_PULSE);

  // Data register update from DATA / OUTSET / OUTCLEAR writes
  always_comb begin
    data_d = data_q;
    if (write_s) begin
      case (address)
        PIO_ADDR_DATA:     data_d = wd_s;
        PIO_ADDR_OUTSET:   data_d = data_q | wd_s;
        PIO_ADDR_OUTCLEAR: data_d = data_q & ~wd_s;
        PIO_ADDR_PULSE:    data_d = data_q;
        default:           data_d = data_q;
      endcase
    end else begin
      data_d = data_q;
    end
  end

  // Read mux, sampled every cycle regardless of chipselect
  always_comb begin
    readdata_d = 32'h0000_0000;
    case (address)
      PIO_ADDR_DATA:     readdata_d = 32'(data_q);
      PIO_ADDR_PULSE:    readdata_d = 32'(pulse_mask_s);
      PIO_ADDR_OUTSET:   readdata_d = 32'h0000_0000;
      PIO_ADDR_OUTCLEAR: readdata_d = 32'h0000_0000;
      default:           readdata_d = 32'h0000_0000;
    endcase
  end

  // Data and read-data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      readdata_q <= 32'h0000_0000;
    end else begin
      data_q     <= data_d;
      readdata_q <= readdata_d;
    end
  end

  bmr_tdee_pulse_timer #(
    .WIDTH        (WIDTH),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_pulse_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (pulse_load_s),
    .load_mask  (wd_s),
    .pulse_mask (pulse_mask_s)
  );

  assign readdata = readdata_q;
  assign out_port = data_q | pulse_mask_s;

endmodule

// File: tb/tb_bmr_tdee_qsys_pio_led.sv
// Directed bench for the output PIO with WIDTH=8, RESET_VALUE=A5, PULSE_CYCLES=4.
module tb_bmr_tdee_qsys_pio_led;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_cmp;
  int n_bad;

  bmr_tdee_qsys_pio_led #(
    .WIDTH        (8),
    .RESET_VALUE  (8'hA5),
    .PULSE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge; the transfer happens on the following posedge.
  task automatic bus_cycle(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_cycle(1'b1, 1'b0, a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_cycle(1'b1, 1'b1, a, 32'h0);
    d = readdata;
  endtask

  task automatic chk_hold(input string tag, input logic [7:0] exp, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk(tag, {24'h0, out_port}, {24'h0, exp});
      @(negedge clk);
    end
  endtask

  logic [31:0] rd;

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    address    = 2'd2;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;

    // 1. reset values and first read
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", {24'h0, out_port}, 32'h0000_00A5);
    chk("rst_rd", readdata, 32'h0);
    reset_n = 1'b1;
    chk("rel_out", {24'h0, out_port}, 32'h0000_00A5);
    chk("rel_rd", readdata, 32'h0);
    bus_read(2'd0, rd);
    chk("rd_data_rst", rd, 32'h0000_00A5);

    // 2. data / set / clear
    bus_write(2'd0, 32'h3C);
    chk("wr_data", {24'h0, out_port}, 32'h3C);
    bus_write(2'd2, 32'h03);
    chk("outset", {24'h0, out_port}, 32'h3F);
    bus_write(2'd3, 32'h30);
    chk("outclr", {24'h0, out_port}, 32'h0F);
    bus_read(2'd2, rd);
    chk("rd_addr2", rd, 32'h0);
    bus_read(2'd3, rd);
    chk("rd_addr3", rd, 32'h0);
    bus_read(2'd0, rd);
    chk("rd_data_0f", rd, 32'h0F);

    // 3. single pulse, exact width
    bus_write(2'd0, 32'h00);
    bus_write(2'd1, 32'h81);
    chk_hold("pulse_hi", 8'h81, 4);
    chk("pulse_end", {24'h0, out_port}, 32'h0);
    bus_write(2'd1, 32'h81);
    bus_read(2'd1, rd);
    chk("rd_mask_mid", rd, 32'h81);
    repeat (3) @(negedge clk);
    chk("pulse2_end", {24'h0, out_port}, 32'h0);
    bus_read(2'd1, rd);
    chk("rd_mask_after", rd, 32'h0);

    // zero pulse write in IDLE does nothing
    bus_write(2'd1, 32'h00);
    chk("pulse_zero", {24'h0, out_port}, 32'h0);

    // 4. retrigger two cycles after first write
    bus_write(2'd1, 32'h01);
    @(negedge clk);
    bus_write(2'd1, 32'h02);
    chk_hold("retrig_hi", 8'h03, 4);
    chk("retrig_end", {24'h0, out_port}, 32'h0);

    // write on the terminal-count cycle keeps only the new bits
    bus_write(2'd1, 32'h01);
    repeat (3) @(negedge clk);
    chk("term_pre", {24'h0, out_port}, 32'h01);
    bus_write(2'd1, 32'h02);
    chk_hold("term_hi", 8'h02, 4);
    chk("term_end", {24'h0, out_port}, 32'h0);

    // overlapping data bit survives the pulse
    bus_write(2'd0, 32'h01);
    bus_write(2'd1, 32'h03);
    chk_hold("ovl_hi", 8'h03, 4);
    chk("ovl_end", {24'h0, out_port}, 32'h01);

    // 5. async reset mid-pulse
    bus_write(2'd1, 32'h0F);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", {24'h0, out_port}, 32'h0000_00A5);
    chk("arst_rd", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("arst_rel", {24'h0, out_port}, 32'h0000_00A5);
    bus_read(2'd1, rd);
    chk("arst_mask", rd, 32'h0);
    bus_write(2'd1, 32'h10);
    chk_hold("arst_pulse", 8'hB5, 4);
    chk("arst_pend", {24'h0, out_port}, 32'h0000_00A5);

    // 6. qualified writes and upper-bit masking
    bus_cycle(1'b0, 1'b0, 2'd0, 32'h00);
    chk("cs0_data", {24'h0, out_port}, 32'hA5);
    bus_cycle(1'b1, 1'b1, 2'd0, 32'h00);
    chk("wn1_data", {24'h0, out_port}, 32'hA5);
    bus_cycle(1'b0, 1'b0, 2'd1, 32'h0F);
    chk("cs0_pulse", {24'h0, out_port}, 32'hA5);
    bus_write(2'd0, 32'hFFFF_FF5A);
    chk("wide_out", {24'h0, out_port}, 32'h5A);
    bus_read(2'd0, rd);
    chk("wide_rd", rd, 32'h0000_005A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
